// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD issue unit: sizes, opcodes, instruction
// field positions, controller states and instruction decode helpers.
package simd_pkg;

    localparam int NUM_INSTR = 32;
    localparam int PC_W      = $clog2(NUM_INSTR);
    localparam int NUM_VREGS = 16;
    localparam int VREG_AW   = $clog2(NUM_VREGS);
    localparam int LANE_W    = 32;
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = LANE_W * NUM_LANES;
    localparam int INSTR_W   = 32;

    // Instruction layout: opcode[18:15] src1[14:10] src2[9:5] dest[4:0]
    localparam int OPC_W     = 4;
    localparam int FIELD_W   = 5;
    localparam int OPC_LSB   = 15;
    localparam int SRC1_LSB  = 10;
    localparam int SRC2_LSB  = 5;
    localparam int DEST_LSB  = 0;
    localparam int DECODE_W  = OPC_LSB + OPC_W;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'd2;
    localparam logic [OPC_W-1:0] OP_AND  = 4'd3;
    localparam logic [OPC_W-1:0] OP_OR   = 4'd4;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'd5;
    localparam logic [OPC_W-1:0] OP_NAND = 4'd6;
    localparam logic [OPC_W-1:0] OP_NOR  = 4'd7;
    localparam logic [OPC_W-1:0] OP_XNOR = 4'd8;
    localparam logic [OPC_W-1:0] OP_DIV  = 4'd9;
    localparam logic [OPC_W-1:0] OP_EQ   = 4'd10;
    localparam logic [OPC_W-1:0] OP_GT   = 4'd11;
    localparam logic [OPC_W-1:0] OP_LT   = 4'd12;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic [OPC_W-1:0]   opcode;
        logic [FIELD_W-1:0] src1;
        logic [FIELD_W-1:0] src2;
        logic [FIELD_W-1:0] dest;
    } instr_t;

    function automatic instr_t decode_instr(input logic [DECODE_W-1:0] w);
        instr_t d;
        d.opcode = w[OPC_LSB  +: OPC_W];
        d.src1   = w[SRC1_LSB +: FIELD_W];
        d.src2   = w[SRC2_LSB +: FIELD_W];
        d.dest   = w[DEST_LSB +: FIELD_W];
        return d;
    endfunction

    // Register fields are 5 bits wide but only 16 registers exist, so the top
    // bit of any field marks the instruction illegal, as do the two unused
    // opcodes between the ALU range and HALT.
    function automatic logic instr_is_illegal(input instr_t d);
        logic bad_opc;
        bad_opc = (d.opcode > OP_LT) && (d.opcode != OP_HALT);
        return bad_opc || d.src1[FIELD_W-1] || d.src2[FIELD_W-1] || d.dest[FIELD_W-1];
    endfunction

endpackage

// File: rtl/simd_issue_unit_if.sv
// Bus between the issue unit and the external simd_alu: the issue unit drives
// opcode and operands, the ALU returns the lane-wise result.
interface simd_issue_unit_if;
    import simd_pkg::*;

    logic [OPC_W-1:0] alu_opcode;
    logic [VEC_W-1:0] alu_operand1;
    logic [VEC_W-1:0] alu_operand2;
    logic [VEC_W-1:0] alu_result;

    modport master (
        output alu_opcode,
        output alu_operand1,
        output alu_operand2,
        input  alu_result
    );

    modport slave (
        input  alu_opcode,
        input  alu_operand1,
        input  alu_operand2,
        output alu_result
    );

endinterface

// File: rtl/simd_vreg_file.sv
// 16 x 128-bit vector register file: three asynchronous read ports (two
// operands plus debug) and one synchronous write port fed either by the
// writeback path or by the external loader.
module simd_vreg_file
    import simd_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [VREG_AW-1:0] raddr1,
    input  logic [VREG_AW-1:0] raddr2,
    input  logic [VREG_AW-1:0] raddr_dbg,
    output logic [VEC_W-1:0]   rdata1,
    output logic [VEC_W-1:0]   rdata2,
    output logic [VEC_W-1:0]   rdata_dbg,
    input  logic               wb_we,
    input  logic [VREG_AW-1:0] wb_addr,
    input  logic [VEC_W-1:0]   wb_data,
    input  logic               ext_we,
    input  logic [VREG_AW-1:0] ext_addr,
    input  logic [VEC_W-1:0]   ext_data
);

    logic               wr_en;
    logic [VREG_AW-1:0] wr_addr;
    logic [VEC_W-1:0]   wr_data;
    logic [VEC_W-1:0]   rf_q [NUM_VREGS];

    // Select the write source; writeback wins although the controller only
    // lets the external port through while idle, so both never coincide.
    always_comb begin
        wr_en   = wb_we | ext_we;
        wr_addr = ext_addr;
        wr_data = ext_data;
        if (wb_we) begin
            wr_addr = wb_addr;
            wr_data = wb_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VREGS; gi++) begin : g_vreg
            logic [VEC_W-1:0] data_reg;

            // One register; cleared by reset because programs rely on a zeroed file.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_reg <= '0;
                end else if (wr_en && (wr_addr == VREG_AW'(gi))) begin
                    data_reg <= wr_data;
                end
            end

            assign rf_q[gi] = data_reg;
        end
    endgenerate

    assign rdata1    = rf_q[raddr1];
    assign rdata2    = rf_q[raddr2];
    assign rdata_dbg = rf_q[raddr_dbg];

endmodule

// File: rtl/simd_issue_unit.sv
// Instruction sequencer in front of simd_alu: holds the program memory and the
// vector register file and steps each instruction through fetch, ALU issue
// and writeback, one instruction at a time.
module simd_issue_unit
    import simd_pkg::*;
#(
    parameter int ALU_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   imem_we,
    input  logic [PC_W-1:0]        imem_waddr,
    input  logic [INSTR_W-1:0]     imem_wdata,
    input  logic                   rf_we_ext,
    input  logic [VREG_AW-1:0]     rf_waddr_ext,
    input  logic [VEC_W-1:0]       rf_wdata_ext,
    input  logic [VREG_AW-1:0]     rf_raddr_dbg,
    output logic [VEC_W-1:0]       rf_rdata_dbg,
    simd_issue_unit_if.master      alu_bus,
    output logic                   busy,
    output logic                   done,
    output logic                   illegal,
    output logic [PC_W-1:0]        pc
);

    localparam int LAT   = (ALU_LATENCY < 1) ? 1 : ALU_LATENCY;
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(NUM_INSTR - 1);

    state_t             state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [VREG_AW-1:0] dest_reg, dest_next;
    logic [OPC_W-1:0]   opc_reg, opc_next;
    logic [VEC_W-1:0]   op1_reg, op1_next;
    logic [VEC_W-1:0]   op2_reg, op2_next;
    logic               illegal_reg, illegal_next;
    logic               wb_we;

    logic               idle;
    logic               imem_wr_ok;
    logic [DECODE_W-1:0] imem_q [NUM_INSTR];
    instr_t             fetch_instr;
    logic               fetch_illegal;
    logic               fetch_halt;
    logic [VEC_W-1:0]   src1_data;
    logic [VEC_W-1:0]   src2_data;

    // Bits above the decoded fields carry no meaning, so they are not stored.
    logic imem_unused_hi;
    assign imem_unused_hi = ^imem_wdata[INSTR_W-1:DECODE_W];

    assign idle       = (state_reg == ST_IDLE);
    assign imem_wr_ok = idle && imem_we;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INSTR; gi++) begin : g_imem
            logic [DECODE_W-1:0] word_reg;

            // One program word; loadable only while idle so a running program is never altered.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    word_reg <= '0;
                end else if (imem_wr_ok && (imem_waddr == PC_W'(gi))) begin
                    word_reg <= imem_wdata[DECODE_W-1:0];
                end
            end

            assign imem_q[gi] = word_reg;
        end
    endgenerate

    assign fetch_instr   = decode_instr(imem_q[pc_reg]);
    assign fetch_illegal = instr_is_illegal(fetch_instr);
    assign fetch_halt    = (fetch_instr.opcode == OP_HALT);

    // Operand reads come straight from the decoded word so that a value
    // written in the previous WB cycle is already visible in FETCH.
    simd_vreg_file u_vreg_file (
        .clk       (clk),
        .reset     (reset),
        .raddr1    (fetch_instr.src1[VREG_AW-1:0]),
        .raddr2    (fetch_instr.src2[VREG_AW-1:0]),
        .raddr_dbg (rf_raddr_dbg),
        .rdata1    (src1_data),
        .rdata2    (src2_data),
        .rdata_dbg (rf_rdata_dbg),
        .wb_we     (wb_we),
        .wb_addr   (dest_reg),
        .wb_data   (alu_bus.alu_result),
        .ext_we    (rf_we_ext && idle),
        .ext_addr  (rf_waddr_ext),
        .ext_data  (rf_wdata_ext)
    );

    // Next-state and datapath-load decisions for the sequencer.
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        cnt_next     = cnt_reg;
        dest_next    = dest_reg;
        opc_next     = opc_reg;
        op1_next     = op1_reg;
        op2_next     = op2_reg;
        illegal_next = 1'b0;
        wb_we        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FETCH;
                    pc_next    = '0;
                end
            end
            ST_FETCH: begin
                if (fetch_illegal) begin
                    // Skip without touching the ALU bus or the register file.
                    illegal_next = 1'b1;
                    if (pc_reg == PC_LAST) begin
                        state_next = ST_FIN;
                    end else begin
                        pc_next    = pc_reg + 1'b1;
                        state_next = ST_FETCH;
                    end
                end else if (fetch_halt) begin
                    state_next = ST_FIN;
                end else begin
                    opc_next   = fetch_instr.opcode;
                    op1_next   = src1_data;
                    op2_next   = src2_data;
                    dest_next  = fetch_instr.dest[VREG_AW-1:0];
                    cnt_next   = '0;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_reg == CNT_W'(LAT - 1)) begin
                    state_next = ST_WB;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_WB: begin
                wb_we = 1'b1;
                if (pc_reg == PC_LAST) begin
                    state_next = ST_FIN;
                end else begin
                    pc_next    = pc_reg + 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and the ALU issue registers; reset aborts any program.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= '0;
            cnt_reg     <= '0;
            dest_reg    <= '0;
            opc_reg     <= '0;
            op1_reg     <= '0;
            op2_reg     <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            cnt_reg     <= cnt_next;
            dest_reg    <= dest_next;
            opc_reg     <= opc_next;
            op1_reg     <= op1_next;
            op2_reg     <= op2_next;
            illegal_reg <= illegal_next;
        end
    end

    assign alu_bus.alu_opcode   = opc_reg;
    assign alu_bus.alu_operand1 = op1_reg;
    assign alu_bus.alu_operand2 = op2_reg;

    assign busy    = !idle;
    assign done    = (state_reg == ST_FIN);
    assign illegal = illegal_reg;
    assign pc      = pc_reg;

endmodule

// File: tb/tb_simd_issue_unit.sv
// Bench for simd_issue_unit: two instances (ALU latency 1 and 2) receive the
// same stimulus, each with its own stub ALU, and are checked against fixed
// expectations and a program-level reference model.
module tb_simd_issue_unit;
    import simd_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               imem_we = 1'b0;
    logic [PC_W-1:0]    imem_waddr = '0;
    logic [INSTR_W-1:0] imem_wdata = '0;
    logic               rf_we_ext = 1'b0;
    logic [VREG_AW-1:0] rf_waddr_ext = '0;
    logic [VEC_W-1:0]   rf_wdata_ext = '0;
    logic [VREG_AW-1:0] rf_raddr_dbg = '0;

    logic [VEC_W-1:0]   rdbg [2];
    logic               busy_w [2];
    logic               done_w [2];
    logic               ill_w [2];
    logic [PC_W-1:0]    pc_w [2];

    simd_issue_unit_if bus0();
    simd_issue_unit_if bus1();
    logic [VEC_W-1:0]  pipe1;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_at [2];
    int ill_cnt [2];
    logic busy_first [2];
    logic busy_after [2];

    localparam logic [VEC_W-1:0] R1V = {32'd20, 32'd15, 32'd10, 32'd5};
    localparam logic [VEC_W-1:0] R2V = {32'd12, 32'd9,  32'd6,  32'd3};

    always #5 clk = ~clk;

    simd_issue_unit #(.ALU_LATENCY(1)) dut0 (
        .clk(clk), .reset(reset), .start(start), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .rf_we_ext(rf_we_ext),
        .rf_waddr_ext(rf_waddr_ext), .rf_wdata_ext(rf_wdata_ext),
        .rf_raddr_dbg(rf_raddr_dbg), .rf_rdata_dbg(rdbg[0]), .alu_bus(bus0),
        .busy(busy_w[0]), .done(done_w[0]), .illegal(ill_w[0]), .pc(pc_w[0])
    );

    simd_issue_unit #(.ALU_LATENCY(2)) dut1 (
        .clk(clk), .reset(reset), .start(start), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .rf_we_ext(rf_we_ext),
        .rf_waddr_ext(rf_waddr_ext), .rf_wdata_ext(rf_wdata_ext),
        .rf_raddr_dbg(rf_raddr_dbg), .rf_rdata_dbg(rdbg[1]), .alu_bus(bus1),
        .busy(busy_w[1]), .done(done_w[1]), .illegal(ill_w[1]), .pc(pc_w[1])
    );

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    // Lane-wise behaviour of simd_alu, used by the stubs and the model.
    function automatic logic [VEC_W-1:0] alu_fn(input logic [3:0] op,
                                                input logic [VEC_W-1:0] a,
                                                input logic [VEC_W-1:0] b);
        logic [VEC_W-1:0] r;
        logic [31:0] x, y, z;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            x = a[i*32 +: 32];
            y = b[i*32 +: 32];
            case (op)
                OP_ADD:  z = x + y;
                OP_SUB:  z = x - y;
                OP_MUL:  z = x * y;
                OP_AND:  z = x & y;
                OP_OR:   z = x | y;
                OP_XOR:  z = x ^ y;
                OP_NAND: z = ~(x & y);
                OP_NOR:  z = ~(x | y);
                OP_XNOR: z = ~(x ^ y);
                OP_DIV:  z = (y == 0) ? 32'hFFFF_FFFF : x / y;
                OP_EQ:   z = {31'b0, x == y};
                OP_GT:   z = {31'b0, x > y};
                OP_LT:   z = {31'b0, x < y};
                default: z = 32'h0;
            endcase
            r[i*32 +: 32] = z;
        end
        return r;
    endfunction

    // Stub ALUs: one register stage for dut0, two for dut1.
    always @(posedge clk) begin
        bus0.alu_result <= alu_fn(bus0.alu_opcode, bus0.alu_operand1, bus0.alu_operand2);
        pipe1           <= alu_fn(bus1.alu_opcode, bus1.alu_operand1, bus1.alu_operand2);
        bus1.alu_result <= pipe1;
    end

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [4:0] d);
        return {13'h0, op, s1, s2, d};
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] idx, input logic [VEC_W-1:0] v);
        rf_waddr_ext = idx;
        rf_wdata_ext = v;
        rf_we_ext    = 1'b1;
        @(posedge clk);
        #1 rf_we_ext = 1'b0;
    endtask

    task automatic write_imem(input logic [4:0] addr, input logic [31:0] w);
        imem_waddr = addr;
        imem_wdata = w;
        imem_we    = 1'b1;
        @(posedge clk);
        #1 imem_we = 1'b0;
    endtask

    task automatic read_rf(input logic [3:0] idx);
        rf_raddr_dbg = idx;
        #1;
    endtask

    // Start a program and watch both instances until each has finished.
    // Cycle 0 is the first FETCH cycle; done_at stays -1 if done never comes.
    task automatic run_prog(input bit poke);
        for (int i = 0; i < 2; i++) begin
            done_at[i] = -1; ill_cnt[i] = 0; busy_first[i] = 1'b0; busy_after[i] = 1'b1;
        end
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (cyc == 0) busy_first[i] = busy_w[i];
                if (done_w[i] && done_at[i] < 0) done_at[i] = cyc;
                if (ill_w[i]) ill_cnt[i]++;
                if (done_at[i] >= 0 && cyc == done_at[i] + 1) busy_after[i] = busy_w[i];
            end
            if (poke && cyc == 1) begin
                start = 1'b1; imem_we = 1'b1; imem_waddr = 5'd1;
                imem_wdata = enc(OP_ADD, 5'd3, 5'd2, 5'd5);
            end else if (poke && cyc == 2) begin
                start = 1'b0; imem_we = 1'b0;
            end
            if (done_at[0] >= 0 && done_at[1] >= 0 &&
                cyc > done_at[0] + 1 && cyc > done_at[1] + 1) break;
        end
        start = 1'b0;
        imem_we = 1'b0;
        $display("run: done_at=%0d/%0d illegal=%0d/%0d", done_at[0], done_at[1], ill_cnt[0], ill_cnt[1]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if ({busy_w[i], done_w[i], ill_w[i]} !== 3'b000)
                $display("FAIL reset_flags dut%0d: got %b expected 000", i, {busy_w[i], done_w[i], ill_w[i]});
            else pass_cnt++;
            total_cnt++;
            if (pc_w[i] !== 5'd0) $display("FAIL reset_pc dut%0d: got %0d expected 0", i, pc_w[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if ({bus0.alu_opcode, bus0.alu_operand1, bus0.alu_operand2, bus1.alu_opcode,
             bus1.alu_operand1, bus1.alu_operand2} !== '0)
            $display("FAIL reset_alu_bus: got %h/%h expected 0", bus0.alu_opcode, bus1.alu_opcode);
        else pass_cnt++;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            logic nz;
            nz = 1'b0;
            for (int r = 0; r < 16; r++) begin
                read_rf(4'(r));
                if (rdbg[i] !== '0) nz = 1'b1;
            end
            total_cnt++;
            if (nz !== 1'b0) $display("FAIL reset_rf_clear dut%0d: got nonzero register expected all 0", i);
            else pass_cnt++;
        end
        $display("test_reset complete");
    endtask

    task automatic test_add_halt();
        apply_reset();
        write_reg(4'd1, R1V);
        write_reg(4'd2, R2V);
        write_imem(5'd0, enc(OP_ADD, 5'd1, 5'd2, 5'd3));
        write_imem(5'd1, enc(OP_HALT, 5'd0, 5'd0, 5'd0));
        run_prog(1'b0);
        read_rf(4'd3);
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if (done_at[i] !== lat(i) + 3)
                $display("FAIL add_done_cycle dut%0d: got %0d expected %0d", i, done_at[i], lat(i) + 3);
            else pass_cnt++;
            total_cnt++;
            if ({busy_first[i], busy_after[i]} !== 2'b10)
                $display("FAIL add_busy dut%0d: got %b expected 10", i, {busy_first[i], busy_after[i]});
            else pass_cnt++;
            total_cnt++;
            if (rdbg[i] !== {32'd32, 32'd24, 32'd16, 32'd8})
                $display("FAIL add_r3 dut%0d: got %h expected 00000020000000180000001000000008", i, rdbg[i]);
            else pass_cnt++;
            total_cnt++;
            if (pc_w[i] !== 5'd1) $display("FAIL add_pc dut%0d: got %0d expected 1", i, pc_w[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_latency();
        apply_reset();
        write_reg(4'd1, R1V);
        write_reg(4'd2, R2V);
        write_imem(5'd0, enc(OP_SUB, 5'd1, 5'd2, 5'd4));
        write_imem(5'd1, enc(OP_AND, 5'd1, 5'd2, 5'd6));
        write_imem(5'd2, enc(OP_HALT, 5'd0, 5'd0, 5'd0));
        run_prog(1'b0);
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if (done_at[i] !== 2 * (lat(i) + 2) + 1)
                $display("FAIL lat_done_cycle dut%0d: got %0d expected %0d", i, done_at[i], 2 * (lat(i) + 2) + 1);
            else pass_cnt++;
            read_rf(4'd4);
            total_cnt++;
            if (rdbg[i] !== {32'd8, 32'd6, 32'd4, 32'd2})
                $display("FAIL lat_r4 dut%0d: got %h expected {8,6,4,2}", i, rdbg[i]);
            else pass_cnt++;
            read_rf(4'd6);
            total_cnt++;
            if (rdbg[i] !== {32'd4, 32'd9, 32'd2, 32'd1})
                $display("FAIL lat_r6 dut%0d: got %h expected {4,9,2,1}", i, rdbg[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_raw();
        apply_reset();
        write_reg(4'd1, R1V);
        write_reg(4'd2, R2V);
        write_imem(5'd0, enc(OP_ADD, 5'd1, 5'd2, 5'd3));
        write_imem(5'd1, enc(OP_ADD, 5'd3, 5'd2, 5'd5));
        write_imem(5'd2, enc(OP_HALT, 5'd0, 5'd0, 5'd0));
        run_prog(1'b0);
        read_rf(4'd5);
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if (rdbg[i] !== {32'd44, 32'd33, 32'd22, 32'd11})
                $display("FAIL raw_r5 dut%0d: got %h expected {44,33,22,11}", i, rdbg[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        write_reg(4'd1, R1V);
        write_reg(4'd2, R2V);
        write_imem(5'd0, enc(4'd13, 5'd1, 5'd2, 5'd3));
        write_imem(5'd1, enc(OP_ADD, 5'd1, 5'd2, 5'b10000));
        write_imem(5'd2, enc(OP_HALT, 5'd0, 5'd0, 5'd0));
        run_prog(1'b0);
        for (int i = 0; i < 2; i++) begin
            logic changed;
            changed = 1'b0;
            for (int r = 0; r < 16; r++) begin
                read_rf(4'(r));
                if (rdbg[i] !== ((r == 1) ? R1V : (r == 2) ? R2V : '0)) changed = 1'b1;
            end
            total_cnt++;
            if (changed !== 1'b0) $display("FAIL ill_rf dut%0d: got modified register expected none", i);
            else pass_cnt++;
            total_cnt++;
            if (ill_cnt[i] !== 2) $display("FAIL ill_pulses dut%0d: got %0d expected 2", i, ill_cnt[i]);
            else pass_cnt++;
            total_cnt++;
            if (pc_w[i] !== 5'd2) $display("FAIL ill_pc dut%0d: got %0d expected 2", i, pc_w[i]);
            else pass_cnt++;
            total_cnt++;
            if (done_at[i] !== 3) $display("FAIL ill_done_cycle dut%0d: got %0d expected 3", i, done_at[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_busy_ignore();
        apply_reset();
        write_reg(4'd1, R1V);
        write_reg(4'd2, R2V);
        write_imem(5'd0, enc(OP_ADD, 5'd1, 5'd2, 5'd3));
        write_imem(5'd1, enc(OP_HALT, 5'd0, 5'd0, 5'd0));
        run_prog(1'b1);
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if (done_at[i] !== lat(i) + 3)
                $display("FAIL busy_done_cycle dut%0d: got %0d expected %0d", i, done_at[i], lat(i) + 3);
            else pass_cnt++;
            read_rf(4'd3);
            total_cnt++;
            if (rdbg[i] !== {32'd32, 32'd24, 32'd16, 32'd8})
                $display("FAIL busy_r3 dut%0d: got %h expected {32,24,16,8}", i, rdbg[i]);
            else pass_cnt++;
            read_rf(4'd5);
            total_cnt++;
            if (rdbg[i] !== '0) $display("FAIL busy_r5 dut%0d: got %h expected 0", i, rdbg[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_abort();
        apply_reset();
        write_reg(4'd1, R1V);
        write_reg(4'd2, R2V);
        write_imem(5'd0, enc(OP_ADD, 5'd1, 5'd2, 5'd3));
        write_imem(5'd1, enc(OP_HALT, 5'd0, 5'd0, 5'd0));
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({busy_w[0], busy_w[1]} !== 2'b11) $display("FAIL abort_busy_exec: got %b expected 11", {busy_w[0], busy_w[1]});
        else pass_cnt++;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if ({busy_w[i], done_w[i], ill_w[i], pc_w[i]} !== 8'h00)
                $display("FAIL abort_outputs dut%0d: got %h expected 00", i, {busy_w[i], done_w[i], ill_w[i], pc_w[i]});
            else pass_cnt++;
        end
        total_cnt++;
        if ({bus0.alu_opcode, bus0.alu_operand1, bus1.alu_opcode, bus1.alu_operand1} !== '0)
            $display("FAIL abort_alu_bus: got %h/%h expected 0", bus0.alu_opcode, bus1.alu_opcode);
        else pass_cnt++;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            read_rf(4'd3);
            total_cnt++;
            if (rdbg[i] !== '0) $display("FAIL abort_r3 dut%0d: got %h expected 0", i, rdbg[i]);
            else pass_cnt++;
            read_rf(4'd1);
            total_cnt++;
            if (rdbg[i] !== '0) $display("FAIL abort_r1_cleared dut%0d: got %h expected 0", i, rdbg[i]);
            else pass_cnt++;
            total_cnt++;
            if ({busy_w[i], pc_w[i]} !== 6'h00)
                $display("FAIL abort_idle dut%0d: got busy=%b pc=%0d expected 0/0", i, busy_w[i], pc_w[i]);
            else pass_cnt++;
        end
        $display("test_reset_abort complete");
    endtask

    // Random 32-instruction program with no HALT: runs to the last address.
    task automatic test_random(input int iter);
        logic [VEC_W-1:0] m [16];
        logic [31:0] w;
        int n_ill, n_legal, kind;
        apply_reset();
        for (int r = 0; r < 16; r++) begin
            m[r] = {$urandom, $urandom, $urandom, $urandom};
            write_reg(4'(r), m[r]);
        end
        n_ill = 0;
        n_legal = 0;
        for (int p = 0; p < 32; p++) begin
            w = $urandom;
            w[18:15] = 4'($urandom_range(0, 12));
            w[14] = 1'b0; w[9] = 1'b0; w[4] = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                kind = $urandom_range(0, 3);
                if (kind == 0) w[18:15] = 4'(13 + $urandom_range(0, 1));
                else if (kind == 1) w[14] = 1'b1;
                else if (kind == 2) w[9] = 1'b1;
                else w[4] = 1'b1;
            end
            write_imem(5'(p), w);
            if (w[18:15] == 4'd13 || w[18:15] == 4'd14 || w[14] || w[9] || w[4]) begin
                n_ill++;
            end else begin
                n_legal++;
                m[w[3:0]] = alu_fn(w[18:15], m[w[13:10]], m[w[8:5]]);
            end
        end
        run_prog(1'b0);
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if (done_at[i] !== n_ill + n_legal * (lat(i) + 2))
                $display("FAIL rand%0d_done_cycle dut%0d: got %0d expected %0d", iter, i, done_at[i],
                         n_ill + n_legal * (lat(i) + 2));
            else pass_cnt++;
            total_cnt++;
            if (ill_cnt[i] !== n_ill) $display("FAIL rand%0d_illegal dut%0d: got %0d expected %0d", iter, i, ill_cnt[i], n_ill);
            else pass_cnt++;
            total_cnt++;
            if (pc_w[i] !== 5'd31) $display("FAIL rand%0d_pc dut%0d: got %0d expected 31", iter, i, pc_w[i]);
            else pass_cnt++;
            for (int r = 0; r < 16; r++) begin
                read_rf(4'(r));
                total_cnt++;
                if (rdbg[i] !== m[r])
                    $display("FAIL rand%0d_r%0d dut%0d: got %h expected %h", iter, r, i, rdbg[i], m[r]);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_halt();
        test_latency();
        test_raw();
        test_illegal();
        test_busy_ignore();
        test_reset_abort();
        for (int k = 0; k < 2; k++) test_random(k);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
